// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and types for the read-side FIFO drain.
package fifo_rd_stream_pkg;

  localparam int unsigned BITS_DEFAULT = 32;
  localparam int unsigned PKT_CNT_W    = 16;

  typedef struct packed {
    logic [BITS_DEFAULT-1:0] data;
  } stream_beat_t;

  // Beat counter width; a 1-beat packet still needs a 1-bit counter.
  function automatic int unsigned beat_cnt_w(input int unsigned pkt_len);
    return (pkt_len > 1) ? $clog2(pkt_len) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus framed output stream, seen from the drain (master) side.
interface fifo_rd_stream_if #(
  parameter int unsigned BITS = fifo_rd_stream_pkg::BITS_DEFAULT
);
  import fifo_rd_stream_pkg::*;

  logic                 rd_en;
  logic [BITS-1:0]      rd_data;
  logic                 rd_empty;
  logic                 out_valid;
  logic                 out_ready;
  logic [BITS-1:0]      out_data;
  logic                 out_last;
  logic [1:0]           out_level;
  logic [PKT_CNT_W-1:0] pkt_count;

  modport master (
    output rd_en,
    input  rd_data,
    input  rd_empty,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last,
    output out_level,
    output pkt_count
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output rd_empty,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last,
    input  out_level,
    input  pkt_count
  );

endinterface

// File: rtl/fifo_rd_stream_buf2.sv
// Two-entry register buffer; entry 0 is the head.
module fifo_rd_stream_buf2 #(
  parameter int unsigned BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [BITS-1:0] push_data,
  input  logic            pop,
  output logic [BITS-1:0] head_data,
  output logic [1:0]      cnt
);

  logic [BITS-1:0] e0_q, e1_q;
  logic [1:0]      cnt_q;
  logic            pop_ok;

  assign pop_ok    = pop && (cnt_q != 2'd0);
  assign head_data = e0_q;
  assign cnt       = cnt_q;

  // Shift on pop; a push together with a pop at count 1 replaces the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= push_data;
          else               e1_q <= push_data;
          if (cnt_q != 2'd2) cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_q <= push_data;
          end else begin
            e0_q <= e1_q;
            e1_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream_sva.sv
// Protocol assertions, bound into every fifo_rd_stream instance.
module fifo_rd_stream_sva #(
  parameter int unsigned BITS      = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic            rd_clk,
  input logic            rd_rst,
  input logic            rd_en,
  input logic            rd_empty,
  input logic [1:0]      buf_cnt,
  input logic            out_valid,
  input logic            out_ready,
  input logic [BITS-1:0] out_data
);

  a_no_read_empty: assert property (@(posedge rd_clk) !(rd_en && rd_empty));

  a_buf_bound: assert property (@(posedge rd_clk) int'(buf_cnt) <= int'(BUF_DEPTH));

  // A stalled beat stays valid and unchanged unless reset intervenes.
  a_stall_stable: assert property (@(posedge rd_clk)
    (out_valid && !out_ready && !rd_rst) |=> (out_valid && $stable(out_data)));

endmodule

bind fifo_rd_stream fifo_rd_stream_sva #(
  .BITS      (BITS),
  .BUF_DEPTH (BUF_DEPTH)
) u_sva (
  .rd_clk    (rd_clk),
  .rd_rst    (rd_rst),
  .rd_en     (rd_en),
  .rd_empty  (rd_empty),
  .buf_cnt   (buf_cnt),
  .out_valid (out_valid),
  .out_ready (out_ready),
  .out_data  (out_data)
);

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a framed valid/ready stream.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned BITS      = BITS_DEFAULT,
  parameter int unsigned PKT_LEN   = 4,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic              rd_clk,
  input logic              rd_rst,
  fifo_rd_stream_if.master bus
);

  localparam int unsigned    BeatW    = beat_cnt_w(PKT_LEN);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(PKT_LEN - 1);
  localparam logic [2:0]     BufMax   = 3'(BUF_DEPTH);

  logic                 rd_en, rd_empty;
  logic [BITS-1:0]      rd_data, out_data;
  logic                 out_valid, out_ready, out_last, pop;
  logic                 inflight_q;
  logic [1:0]           buf_cnt;
  logic [2:0]           occ, occ_after;
  logic [BeatW-1:0]     beat_cnt_q;
  logic [PKT_CNT_W-1:0] pkt_count_q;

  assign rd_empty  = bus.rd_empty;
  assign rd_data   = bus.rd_data;
  assign out_ready = bus.out_ready;

  // Credit check counts the read already in flight and frees a slot on a same-cycle pop.
  always_comb begin
    pop       = out_valid && out_ready;
    occ       = {1'b0, buf_cnt} + {2'b0, inflight_q};
    occ_after = occ - {2'b0, pop};
    rd_en     = !rd_rst && !rd_empty && (occ_after < BufMax);
    out_valid = (buf_cnt != 2'd0);
    out_last  = out_valid && (beat_cnt_q == LastBeat);
  end

  fifo_rd_stream_buf2 #(
    .BITS (BITS)
  ) u_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (inflight_q),
    .push_data (rd_data),
    .pop       (pop),
    .head_data (out_data),
    .cnt       (buf_cnt)
  );

  // Read-latency tracker, beat framing and packet counter.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight_q  <= 1'b0;
      beat_cnt_q  <= '0;
      pkt_count_q <= '0;
    end else begin
      inflight_q <= rd_en;
      if (pop) begin
        beat_cnt_q <= (beat_cnt_q == LastBeat) ? '0 : beat_cnt_q + BeatW'(1);
        if (out_last) pkt_count_q <= pkt_count_q + PKT_CNT_W'(1);
      end
    end
  end

  assign bus.rd_en     = rd_en;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign bus.out_level = (occ > 3'd2) ? 2'd2 : occ[1:0];
  assign bus.pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomized checks of fifo_rd_stream with PKT_LEN=4 and PKT_LEN=1.
module tb_fifo_rd_stream;
  import fifo_rd_stream_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst1;

  fifo_rd_stream_if #(.BITS(32)) b4 ();
  fifo_rd_stream_if #(.BITS(32)) b1 ();

  fifo_rd_stream #(.BITS(32), .PKT_LEN(4), .BUF_DEPTH(2)) u_dut4 (
    .rd_clk (clk),
    .rd_rst (rst4),
    .bus    (b4)
  );

  fifo_rd_stream #(.BITS(32), .PKT_LEN(1), .BUF_DEPTH(2)) u_dut1 (
    .rd_clk (clk),
    .rd_rst (rst1),
    .bus    (b1)
  );

  // FIFO models: registered read data, flushed by the same reset as the drain.
  logic [31:0] mem4 [0:16383];
  logic [31:0] mem1 [0:15];
  int wptr4 = 0, rptr4 = 0, wptr1 = 0, rptr1 = 0;

  assign b4.rd_empty = (wptr4 == rptr4);
  assign b1.rd_empty = (wptr1 == rptr1);

  always @(posedge clk) begin
    if (rst4) begin
      rptr4      <= wptr4;
      b4.rd_data <= '0;
    end else if (b4.rd_en) begin
      b4.rd_data <= mem4[rptr4[13:0]];
      rptr4      <= rptr4 + 1;
    end
  end

  always @(posedge clk) begin
    if (rst1) begin
      rptr1      <= wptr1;
      b1.rd_data <= '0;
    end else if (b1.rd_en) begin
      b1.rd_data <= mem1[rptr1[3:0]];
      rptr1      <= rptr1 + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [32:0] cap4 [$];
  logic [32:0] cap1 [$];

  // One clock: record accepted beats mid-cycle, return just after the next edge.
  task automatic tick();
    @(negedge clk);
    if (b4.out_valid && b4.out_ready) cap4.push_back({b4.out_last, b4.out_data});
    if (b1.out_valid && b1.out_ready) cap1.push_back({b1.out_last, b1.out_data});
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [31:0] d);
    mem4[wptr4[13:0]] = d;
    wptr4++;
  endtask

  task automatic push1(input logic [31:0] d);
    mem1[wptr1[3:0]] = d;
    wptr1++;
  endtask

  task automatic reset4();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    #1;
  endtask

  logic         stalled_prev;
  logic [31:0]  prev_data;
  logic [32:0]  v;
  logic [31:0]  d;
  stream_beat_t exp_q [$];
  int           sent, got;

  initial begin
    rst4 = 1'b1;
    rst1 = 1'b1;
    b4.out_ready = 1'b0;
    b1.out_ready = 1'b0;
    tick();
    tick();
    rst4 = 1'b0;
    rst1 = 1'b0;
    #1;

    // Reset state with an empty FIFO.
    check_eq("t1_out_data", b4.out_data, 0);
    check_eq("t1_out_last", b4.out_last, 0);
    for (int i = 0; i < 5; i++) begin
      check_eq("t1_rd_en", b4.rd_en, 0);
      check_eq("t1_out_valid", b4.out_valid, 0);
      check_eq("t1_out_level", b4.out_level, 0);
      check_eq("t1_pkt_count", b4.pkt_count, 0);
      tick();
    end

    // Full-rate streaming: first beat two cycles after the first read.
    b4.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push4(32'h10 + i);
    #1;
    check_eq("t2_rd_en_first", b4.rd_en, 1);
    check_eq("t2_valid_n0", b4.out_valid, 0);
    tick();
    check_eq("t2_valid_n1", b4.out_valid, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check_eq("t2_valid", b4.out_valid, 1);
      check_eq("t2_data", b4.out_data, 64'h10 + i);
      check_eq("t2_last", b4.out_last, (i % 4 == 3) ? 1 : 0);
      tick();
    end
    check_eq("t2_valid_end", b4.out_valid, 0);
    check_eq("t2_pkt_count", b4.pkt_count, 2);

    // Ready pattern 1,0,0,1.
    reset4();
    cap4.delete();
    stalled_prev = 1'b0;
    prev_data    = '0;
    for (int i = 0; i < 8; i++) push4(32'h10 + i);
    for (int c = 0; c < 80 && cap4.size() < 8; c++) begin
      b4.out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      #1;
      if (b4.out_level == 2'd2 && !b4.out_ready) check_eq("t3_rd_en_full", b4.rd_en, 0);
      if (stalled_prev) check_eq("t3_hold", b4.out_data, prev_data);
      stalled_prev = b4.out_valid && !b4.out_ready;
      prev_data    = b4.out_data;
      tick();
    end
    check_eq("t3_count", cap4.size(), 8);
    for (int i = 0; i < 8 && i < cap4.size(); i++)
      check_eq("t3_beat", cap4[i], {(i % 4 == 3) ? 1'b1 : 1'b0, 32'h10 + 32'(i)});
    check_eq("t3_pkt_count", b4.pkt_count, 2);

    // FIFO runs empty mid-packet; framing resumes.
    reset4();
    cap4.delete();
    b4.out_ready = 1'b1;
    push4(32'hA0);
    push4(32'hA1);
    repeat (10) tick();
    check_eq("t4_valid_gap", b4.out_valid, 0);
    check_eq("t4_beat_held", u_dut4.beat_cnt_q, 2);
    push4(32'hA2);
    push4(32'hA3);
    repeat (10) tick();
    check_eq("t4_count", cap4.size(), 4);
    for (int i = 0; i < 4 && i < cap4.size(); i++)
      check_eq("t4_beat", cap4[i], {(i == 3) ? 1'b1 : 1'b0, 32'hA0 + 32'(i)});
    check_eq("t4_pkt_count", b4.pkt_count, 1);

    // Reset with a buffered beat and a read in flight.
    reset4();
    b4.out_ready = 1'b1;
    push4(32'h30);
    repeat (4) tick();
    check_eq("t5_beat_pre", u_dut4.beat_cnt_q, 1);
    b4.out_ready = 1'b0;
    push4(32'h31);
    push4(32'h32);
    push4(32'h33);
    #1;
    check_eq("t5_rd_en", b4.rd_en, 1);
    tick();
    tick();
    check_eq("t5_level_pre", b4.out_level, 2);
    check_eq("t5_inflight_pre", u_dut4.inflight_q, 1);
    rst4 = 1'b1;
    #1;
    check_eq("t5_rd_en_in_rst", b4.rd_en, 0);
    tick();
    rst4 = 1'b0;
    #1;
    check_eq("t5_valid", b4.out_valid, 0);
    check_eq("t5_level", b4.out_level, 0);
    check_eq("t5_beat", u_dut4.beat_cnt_q, 0);
    check_eq("t5_rd_en_post", b4.rd_en, 0);
    cap4.delete();
    b4.out_ready = 1'b1;
    push4(32'h55);
    repeat (4) tick();
    check_eq("t5_count", cap4.size(), 1);
    if (cap4.size() > 0) check_eq("t5_beat55", cap4[0], {1'b0, 32'h55});

    // PKT_LEN=1: every beat closes a packet.
    b1.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push1(32'h61 + i);
    repeat (8) tick();
    check_eq("t6_count", cap1.size(), 3);
    for (int i = 0; i < 3 && i < cap1.size(); i++)
      check_eq("t6_beat", cap1[i], {1'b1, 32'h61 + 32'(i)});
    check_eq("t6_pkt_count", b1.pkt_count, 3);

    // Random producer and consumer against a scoreboard.
    reset4();
    cap4.delete();
    sent = 0;
    got  = 0;
    for (int c = 0; c < 60000 && got < 10000; c++) begin
      if (sent < 10000 && $urandom_range(0, 1) == 1) begin
        d = $urandom;
        push4(d);
        exp_q.push_back('{data: d});
        sent++;
      end
      b4.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      while (cap4.size() > 0) begin
        v = cap4.pop_front();
        if (exp_q.size() > 0) begin
          check_eq("rnd_beat", v, {(got % 4 == 3) ? 1'b1 : 1'b0, exp_q.pop_front().data});
        end else begin
          check_eq("rnd_extra_beat", v, 33'h0_dead_beef);
        end
        got++;
      end
    end
    check_eq("rnd_count", got, 10000);
    check_eq("rnd_pkt_count", b4.pkt_count, 2500);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
